// File: rtl/single_imem_loader.sv
// single_imem_loader: takes a length-prefixed, XOR-checksummed byte stream and writes
// big-endian 32-bit words into instruction memory from word 0. While loading, the CPU
// is held in reset.
module single_imem_loader #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] imem_addra,
    output logic [31:0]       imem_dina,
    output logic              imem_wea,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned TW        = $clog2(TIMEOUT + 1);
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_nx;
    logic              xfer;
    logic              timed_out;
    logic              last_word;
    logic [7:0]        cnt_hi;
    logic [15:0]       hdr_cnt;
    logic [15:0]       word_cnt;
    logic [ADDR_W:0]   word_idx;
    logic [1:0]        byte_idx;
    logic [31:0]       word_reg;
    logic [7:0]        chk;
    logic [TW-1:0]     idle_cnt;

    assign byte_ready = (state == S_HDR_HI) || (state == S_HDR_LO) ||
                        (state == S_DATA)   || (state == S_CHK);
    assign xfer       = byte_valid & byte_ready;
    assign hdr_cnt    = {cnt_hi, byte_data};
    assign timed_out  = byte_ready && !xfer && (idle_cnt == TW'(TIMEOUT - 1));
    assign last_word  = (32'(word_idx) + 32'd1) == 32'(word_cnt);
    assign imem_addra = word_idx[ADDR_W-1:0];
    assign imem_dina  = word_reg;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state decode and per-state strobes; a timeout overrides any byte-waiting state
    always_comb begin
        state_nx = state;
        imem_wea = 1'b0;
        busy     = byte_ready || (state == S_WRITE);
        case (state)
            S_IDLE:   if (start) state_nx = S_HDR_HI;
            S_HDR_HI: if (xfer) state_nx = S_HDR_LO;
            S_HDR_LO: begin
                if (xfer) begin
                    if ({1'b0, hdr_cnt} > MAX_WORDS) state_nx = S_ERR;
                    else if (hdr_cnt == 16'd0)       state_nx = S_CHK;
                    else                             state_nx = S_DATA;
                end
            end
            S_DATA:   if (xfer && (byte_idx == 2'd3)) state_nx = S_WRITE;
            S_WRITE: begin
                imem_wea = 1'b1;
                state_nx = last_word ? S_CHK : S_DATA;
            end
            S_CHK: begin
                if (xfer) state_nx = (byte_data == chk) ? S_DONE : S_ERR;
            end
            S_DONE:   state_nx = S_IDLE;
            S_ERR:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        if (timed_out) state_nx = S_ERR;
    end

    // Datapath: header capture, word assembly, checksum, idle timer and sticky status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_hi   <= '0;
            word_cnt <= '0;
            word_idx <= '0;
            byte_idx <= '0;
            word_reg <= '0;
            chk      <= '0;
            idle_cnt <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (xfer)            idle_cnt <= '0;
            else if (byte_ready) idle_cnt <= idle_cnt + TW'(1);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                        word_idx <= '0;
                        byte_idx <= '0;
                        chk      <= '0;
                        idle_cnt <= '0;
                    end
                end
                S_HDR_HI: if (xfer) cnt_hi <= byte_data;
                S_HDR_LO: begin
                    if (xfer) begin
                        word_cnt <= hdr_cnt;
                        byte_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        word_reg <= {word_reg[23:0], byte_data};
                        chk      <= chk ^ byte_data;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                S_WRITE:  word_idx <= word_idx + (ADDR_W + 1)'(1);
                default:  ;
            endcase

            if (state_nx == S_DONE) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end
            if ((state_nx == S_ERR) && (state != S_ERR)) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_single_imem_loader.sv
// tb_single_imem_loader: directed and randomized image loads checked against a
// stream-level reference model (header parse, word list, XOR checksum).
module tb_single_imem_loader;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned TIMEOUT = 40;
    localparam int unsigned DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic [ADDR_W-1:0] imem_addra;
    logic [31:0]       imem_dina;
    logic              imem_wea;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    single_imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_addra (imem_addra),
        .imem_dina  (imem_dina),
        .imem_wea   (imem_wea),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int unsigned       n_checks = 0;
    int unsigned       n_fail   = 0;
    logic [7:0]        stream[$];
    logic [31:0]       exp_w[$];
    logic [ADDR_W-1:0] cap_a[$];
    logic [31:0]       cap_d[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record every write strobe and its surroundings
    always @(negedge clk) begin
        if (imem_wea === 1'b1) begin
            cap_a.push_back(imem_addra);
            cap_d.push_back(imem_dina);
            check("ready_low_in_write", 32'(byte_ready), 32'd0);
            check("hold_in_write", 32'(cpu_hold), 32'd1);
        end
    end

    // Reference: parse the stream, list the words to be written, decide done vs err
    task automatic model(output int unsigned nbytes, output bit ok);
        int unsigned n;
        logic [7:0]  c;
        n = 32'({stream[0], stream[1]});
        exp_w.delete();
        if (n > DEPTH) begin
            nbytes = 2;
            ok     = 1'b0;
            return;
        end
        c = 8'h00;
        for (int unsigned i = 0; i < n; i++) begin
            exp_w.push_back({stream[2+4*i], stream[3+4*i], stream[4+4*i], stream[5+4*i]});
            c = c ^ stream[2+4*i] ^ stream[3+4*i] ^ stream[4+4*i] ^ stream[5+4*i];
        end
        nbytes = 3 + 4 * n;
        ok     = (stream[2+4*n] == c);
    endtask

    task automatic push_word(input logic [31:0] w);
        stream.push_back(w[31:24]);
        stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
    endtask

    task automatic push_chk(input bit bad);
        logic [7:0] c = 8'h00;
        for (int unsigned i = 2; i < stream.size(); i++) c = c ^ stream[i];
        if (bad) c = c ^ 8'($urandom_range(255, 1));
        stream.push_back(c);
    endtask

    task automatic make_random(input int unsigned n, input bit bad);
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        for (int unsigned i = 0; i < n; i++) push_word($urandom);
        push_chk(bad);
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte transferred
    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("byte_accept_bound", 32'(byte_ready), 32'd1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start(input bit with_valid);
        start      = 1'b1;
        byte_valid = with_valid;
        byte_data  = 8'hA5;
        @(posedge clk); #1;
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic run_load(input bit valid_at_start, input bit glitch_start, input int unsigned max_gap);
        int unsigned nb;
        bit          ok;
        int unsigned w = 0;
        model(nb, ok);
        cap_a.delete();
        cap_d.delete();
        pulse_start(valid_at_start);
        check("start_busy", 32'(busy), 32'd1);
        check("start_hold", 32'(cpu_hold), 32'd1);
        check("start_done_clr", 32'(done), 32'd0);
        check("start_err_clr", 32'(err), 32'd0);
        for (int unsigned i = 0; i < nb; i++) begin
            send_byte(stream[i]);
            if (glitch_start && i == 3) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (i + 1 < nb) repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
        end
        while (busy === 1'b1 && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        check("end_busy", 32'(busy), 32'd0);
        check("end_done", 32'(done), 32'(ok));
        check("end_err", 32'(err), 32'(!ok));
        check("end_hold", 32'(cpu_hold), 32'(!ok));
        check("write_count", 32'(cap_a.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < cap_a.size(); i++) begin
            check("write_addr", 32'(cap_a[i]), 32'(i));
            check("write_data", cap_d[i], exp_w[i]);
        end
        @(posedge clk); #1;
        check("sticky_done", 32'(done), 32'(ok));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_addr"}, 32'(imem_addra), 32'd0);
        check({tag, "_dina"}, imem_dina, 32'd0);
        check({tag, "_wea"}, 32'(imem_wea), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #3;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Single word 0x12345678
        stream.delete();
        stream.push_back(8'h00);
        stream.push_back(8'h01);
        push_word(32'h12345678);
        push_chk(1'b0);
        run_load(1'b0, 1'b0, 0);

        // Three instruction words, good checksum
        stream.delete();
        stream.push_back(8'h00);
        stream.push_back(8'h03);
        push_word(32'h20080005);
        push_word(32'h20090007);
        push_word(32'h01095020);
        push_chk(1'b0);
        run_load(1'b0, 1'b0, 2);

        // One word, corrupted checksum: word still lands, err set, CPU stays held
        make_random(1, 1'b1);
        run_load(1'b0, 1'b0, 1);

        // Count one beyond capacity: error straight after the count bytes
        stream.delete();
        stream.push_back(8'h04);
        stream.push_back(8'h01);
        run_load(1'b0, 1'b0, 0);

        // Empty image
        stream.delete();
        stream.push_back(8'h00);
        stream.push_back(8'h00);
        stream.push_back(8'h00);
        run_load(1'b0, 1'b0, 0);

        // Stall after two data bytes
        cap_a.delete();
        cap_d.delete();
        pulse_start(1'b0);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        repeat (TIMEOUT - 2) begin @(posedge clk); #1; end
        check("stall_still_busy", 32'(busy), 32'd1);
        check("stall_no_err_yet", 32'(err), 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_done", 32'(done), 32'd0);
        check("timeout_hold", 32'(cpu_hold), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_writes", 32'(cap_a.size()), 32'd0);

        // Good load so done is set, then reset mid-DATA of the next one
        make_random(2, 1'b0);
        run_load(1'b0, 1'b0, 0);
        cap_a.delete();
        cap_d.delete();
        pulse_start(1'b0);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hDE);
        send_byte(8'hAD);
        #2 rst = 1'b0;
        #1 check_all_zero("abort");
        #1 rst = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_ready", 32'(byte_ready), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
        byte_valid = 1'b0;
        check("idle_no_writes", 32'(cap_a.size()), 32'd0);

        // Byte alongside start is dropped; start mid-load is ignored
        make_random(3, 1'b0);
        run_load(1'b1, 1'b1, 1);

        // Random loads
        for (int k = 0; k < 6; k++) begin
            make_random($urandom_range(6, 1), 1'($urandom_range(1, 0)));
            run_load(1'($urandom_range(1, 0)), 1'b0, 2);
        end

        // Fill memory to capacity: no address wrap
        make_random(DEPTH, 1'b0);
        run_load(1'b0, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
